ddr_init_seq: RTL and testbench

//  DDR3 power-up/initialisation sequencer; sits directly upstream of calibration control.
//  On init_start it drives DRAM reset and CKE timing, then issues MR2, MR3, MR1, MR0 and ZQCL on the DFI command bus.

---
 rtl/ddr_init_seq.sv | 210 +++++++++++++++++++++
 tb/tb_ddr_init_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ddr_init_seq.sv
// ============================================================================
// Module      : ddr_init_seq
// Description : DDR3 power-up sequencer: reset/CKE timing, MR2/MR3/MR1/MR0, ZQCL.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_init_seq #(
   parameter int              ADDR_W   = 14,
   parameter int              BANK_W   = 3,
   parameter int              CNT_W    = 20,
   parameter int              T_RESET  = 100000,
   parameter int              T_CKE    = 250000,
   parameter int              T_XPR    = 60,
   parameter int              T_MRD    = 4,
   parameter int              T_MOD    = 12,
   parameter int              T_ZQINIT = 512,
   parameter logic [ADDR_W-1:0] MR0    = '0,
   parameter logic [ADDR_W-1:0] MR1    = '0,
   parameter logic [ADDR_W-1:0] MR2    = '0,
   parameter logic [ADDR_W-1:0] MR3    = '0
) (
   input  logic              core_clk,
   input  logic              core_arstn,
   input  logic              init_start,
   output logic              init_busy,
   output logic              init_done,
   output logic              dfi_reset_n,
   output logic              dfi_cke,
   output logic              dfi_cs_n,
   output logic              dfi_ras_n,
   output logic              dfi_cas_n,
   output logic              dfi_we_n,
   output logic [BANK_W-1:0] dfi_bank,
   output logic [ADDR_W-1:0] dfi_address,
   output logic              dfi_odt
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_RST_HOLD = 4'd1,
      S_CKE_WAIT = 4'd2,
      S_XPR      = 4'd3,
      S_MRS2     = 4'd4,
      S_MRS3     = 4'd5,
      S_MRS1     = 4'd6,
      S_MRS0     = 4'd7,
      S_ZQCL     = 4'd8,
      S_DONE     = 4'd9
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               w_expired;
   logic               w_entry;

   logic               w_reset_n, w_cke, w_cs_n, w_ras_n, w_cas_n, w_we_n;
   logic               w_busy, w_done;
   logic [BANK_W-1:0]  w_bank;
   logic [ADDR_W-1:0]  w_addr;

   assign w_expired = (r_cnt == '0);

   // Next state and wait counter; each timed state exits the cycle after count==0
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (init_start) begin
               w_state_nxt = S_RST_HOLD;
               w_cnt_nxt   = CNT_W'(T_RESET - 1);
            end
         end
         S_RST_HOLD: if (w_expired) begin
            w_state_nxt = S_CKE_WAIT;
            w_cnt_nxt   = CNT_W'(T_CKE - 1);
         end else w_cnt_nxt = r_cnt - 1'b1;
         S_CKE_WAIT: if (w_expired) begin
            w_state_nxt = S_XPR;
            w_cnt_nxt   = CNT_W'(T_XPR - 1);
         end else w_cnt_nxt = r_cnt - 1'b1;
         S_XPR: if (w_expired) begin
            w_state_nxt = S_MRS2;
            w_cnt_nxt   = CNT_W'(T_MRD - 1);
         end else w_cnt_nxt = r_cnt - 1'b1;
         S_MRS2: if (w_expired) begin
            w_state_nxt = S_MRS3;
            w_cnt_nxt   = CNT_W'(T_MRD - 1);
         end else w_cnt_nxt = r_cnt - 1'b1;
         S_MRS3: if (w_expired) begin
            w_state_nxt = S_MRS1;
            w_cnt_nxt   = CNT_W'(T_MRD - 1);
         end else w_cnt_nxt = r_cnt - 1'b1;
         S_MRS1: if (w_expired) begin
            w_state_nxt = S_MRS0;
            w_cnt_nxt   = CNT_W'(T_MOD - 1);
         end else w_cnt_nxt = r_cnt - 1'b1;
         S_MRS0: if (w_expired) begin
            w_state_nxt = S_ZQCL;
            w_cnt_nxt   = CNT_W'(T_ZQINIT - 1);
         end else w_cnt_nxt = r_cnt - 1'b1;
         S_ZQCL: if (w_expired) begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = '0;
         end else w_cnt_nxt = r_cnt - 1'b1;
         S_DONE: begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = '0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are decoded from the upcoming state so they register alongside it;
   // the command cycle is the first cycle of an MRS/ZQCL state.
   assign w_entry = (w_state_nxt != r_state);

   always_comb begin
      w_reset_n = 1'b1;
      w_cke     = 1'b1;
      w_cs_n    = 1'b0;
      w_ras_n   = 1'b1;
      w_cas_n   = 1'b1;
      w_we_n    = 1'b1;
      w_bank    = '0;
      w_addr    = '0;
      w_busy    = 1'b1;
      w_done    = 1'b0;
      case (w_state_nxt)
         S_IDLE: begin
            w_reset_n = 1'b0;
            w_cke     = 1'b0;
            w_cs_n    = 1'b1;
            w_busy    = 1'b0;
         end
         S_RST_HOLD: begin
            w_reset_n = 1'b0;
            w_cke     = 1'b0;
            w_cs_n    = 1'b1;
         end
         S_CKE_WAIT: begin
            w_cke  = 1'b0;
            w_cs_n = 1'b1;
         end
         S_MRS2, S_MRS3, S_MRS1, S_MRS0: begin
            if (w_entry) begin
               w_ras_n = 1'b0;
               w_cas_n = 1'b0;
               w_we_n  = 1'b0;
               case (w_state_nxt)
                  S_MRS2:  begin w_bank = BANK_W'(2); w_addr = MR2; end
                  S_MRS3:  begin w_bank = BANK_W'(3); w_addr = MR3; end
                  S_MRS1:  begin w_bank = BANK_W'(1); w_addr = MR1; end
                  default: begin w_bank = BANK_W'(0); w_addr = MR0; end
               endcase
            end
         end
         S_ZQCL: begin
            if (w_entry) begin
               w_we_n     = 1'b0;
               w_addr[10] = 1'b1;
            end
         end
         S_DONE: begin
            w_busy = 1'b0;
            w_done = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge core_clk or negedge core_arstn) begin
      if (!core_arstn) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         dfi_reset_n <= 1'b0;
         dfi_cke     <= 1'b0;
         dfi_cs_n    <= 1'b1;
         dfi_ras_n   <= 1'b1;
         dfi_cas_n   <= 1'b1;
         dfi_we_n    <= 1'b1;
         dfi_bank    <= '0;
         dfi_address <= '0;
         dfi_odt     <= 1'b0;
         init_busy   <= 1'b0;
         init_done   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         dfi_reset_n <= w_reset_n;
         dfi_cke     <= w_cke;
         dfi_cs_n    <= w_cs_n;
         dfi_ras_n   <= w_ras_n;
         dfi_cas_n   <= w_cas_n;
         dfi_we_n    <= w_we_n;
         dfi_bank    <= w_bank;
         dfi_address <= w_addr;
         dfi_odt     <= 1'b0;
         init_busy   <= w_busy;
         init_done   <= w_done;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ddr_init_seq.sv
// ============================================================================
// Module      : tb_ddr_init_seq
// Description : Directed self-checking bench for ddr_init_seq with short timings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ddr_init_seq;

   logic        core_clk = 1'b0;
   logic        core_arstn;
   logic        init_start;
   logic        init_busy, init_done;
   logic        dfi_reset_n, dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
   logic [2:0]  dfi_bank;
   logic [13:0] dfi_address;
   logic        dfi_odt;

   ddr_init_seq #(
      .ADDR_W(14), .BANK_W(3), .CNT_W(20),
      .T_RESET(8), .T_CKE(10), .T_XPR(5), .T_MRD(4), .T_MOD(12), .T_ZQINIT(16),
      .MR0(14'h1520), .MR1(14'h0044), .MR2(14'h0008), .MR3(14'h0000)
   ) dut (
      .core_clk(core_clk), .core_arstn(core_arstn), .init_start(init_start),
      .init_busy(init_busy), .init_done(init_done),
      .dfi_reset_n(dfi_reset_n), .dfi_cke(dfi_cke), .dfi_cs_n(dfi_cs_n),
      .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n),
      .dfi_bank(dfi_bank), .dfi_address(dfi_address), .dfi_odt(dfi_odt)
   );

   always #5 core_clk = ~core_clk;

   typedef struct packed {
      logic [31:0] cyc;
      logic [3:0]  cmd;
      logic [2:0]  bank;
      logic [13:0] addr;
   } cmd_t;

   localparam logic [31:0] RESET_BUS = {6'd0, 1'b0, 1'b0, 4'b1111, 3'd0, 14'd0, 3'b000};
   localparam logic [31:0] DONE_BUS  = {6'd0, 1'b1, 1'b1, 4'b0111, 3'd0, 14'd0, 3'b001};

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   t_busy = -1, t_rst = -1, t_cke = -1, t_done = -1;
   int   cs_bad = 0, total_cmds = 0, done_fall = 0;
   logic p_rst = 1'b0, p_cke = 1'b0, p_busy = 1'b0, p_done = 1'b0;
   cmd_t cmds[$];

   function automatic logic [31:0] bus();
      return {6'd0, dfi_reset_n, dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n,
              dfi_bank, dfi_address, dfi_odt, init_busy, init_done};
   endfunction

   // Passive recorder: command log and edge timestamps, sampled on the falling edge
   always @(negedge core_clk) begin
      cyc = cyc + 1;
      if (!dfi_cs_n && !(dfi_ras_n && dfi_cas_n && dfi_we_n)) begin
         cmds.push_back({32'(cyc), {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n}, dfi_bank, dfi_address});
         total_cmds = total_cmds + 1;
      end
      if (!dfi_cke && !dfi_cs_n) cs_bad = cs_bad + 1;
      if (init_busy && !p_busy)   t_busy = cyc;
      if (dfi_reset_n && !p_rst)  t_rst  = cyc;
      if (dfi_cke && !p_cke)      t_cke  = cyc;
      if (init_done && !p_done)   t_done = cyc;
      if (!init_done && p_done)   done_fall = done_fall + 1;
      p_rst  = dfi_reset_n;
      p_cke  = dfi_cke;
      p_busy = init_busy;
      p_done = init_done;
   end

   task automatic tick();
      @(negedge core_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec = n_vec + 1;
      assert (obs === exp) else begin
         n_err = n_err + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      cmds.delete();
      t_busy = -1; t_rst = -1; t_cke = -1; t_done = -1;
   endtask

   task automatic pulse_start();
      init_start = 1'b1;
      tick();
      init_start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400 && !init_done; i++) tick();
      chk("done_timeout", 32'(init_done), 32'd1);
   endtask

   // Checks one complete initialisation run against hand-derived timing
   task automatic check_run(input string name);
      logic [2:0]  exp_bank[5] = '{3'd2, 3'd3, 3'd1, 3'd0, 3'd0};
      logic [13:0] exp_addr[5] = '{14'h0008, 14'h0000, 14'h0044, 14'h1520, 14'h0400};
      logic [3:0]  exp_cmd[5]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0110};
      int          exp_gap[5]  = '{5, 4, 4, 4, 12};
      int          prev;
      cmd_t        c;
      chk({name, "_reset_low_len"}, 32'(t_rst - t_busy), 32'd8);
      chk({name, "_cke_delay"},     32'(t_cke - t_rst),  32'd10);
      chk({name, "_cmd_count"},     32'(cmds.size()),    32'd5);
      prev = t_cke;
      for (int i = 0; i < 5; i++) begin
         c = (i < cmds.size()) ? cmds[i] : '0;
         chk($sformatf("%s_cmd%0d_type", name, i), 32'(c.cmd),  32'(exp_cmd[i]));
         chk($sformatf("%s_cmd%0d_bank", name, i), 32'(c.bank), 32'(exp_bank[i]));
         chk($sformatf("%s_cmd%0d_addr", name, i), 32'(c.addr), 32'(exp_addr[i]));
         chk($sformatf("%s_cmd%0d_gap",  name, i), 32'(int'(c.cyc) - prev), 32'(exp_gap[i]));
         prev = int'(c.cyc);
      end
      chk({name, "_done_delay"}, 32'(t_done - prev), 32'd16);
      chk({name, "_done_bus"},   bus(), DONE_BUS);
   endtask

   initial begin
      core_arstn = 1'b0;
      init_start = 1'b0;
      repeat (3) tick();
      chk("reset_values", bus(), RESET_BUS);

      // Idle with no start request
      core_arstn = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         chk("idle_hold", bus(), RESET_BUS);
      end

      // Full sequence
      clear_log();
      pulse_start();
      wait_done();
      tick();
      check_run("run1");

      // DONE is sticky and ignores init_start, pulsed or held
      pulse_start();
      repeat (5) tick();
      init_start = 1'b1;
      repeat (10) tick();
      init_start = 1'b0;
      repeat (5) tick();
      chk("done_no_cmds", 32'(cmds.size()), 32'd5);
      chk("done_sticky",  32'(done_fall),   32'd0);
      chk("done_bus_after_start", bus(), DONE_BUS);

      // Reset during MRS1's wait, then rerun
      core_arstn = 1'b0;
      tick();
      core_arstn = 1'b1;
      tick();
      clear_log();
      pulse_start();
      for (int i = 0; i < 400 && cmds.size() < 3; i++) tick();
      chk("mrs1_reached", 32'(cmds.size()), 32'd3);
      tick();
      chk("mrs1_wait_busy", 32'(init_busy), 32'd1);
      core_arstn = 1'b0;
      tick();
      chk("abort_bus", bus(), RESET_BUS);
      tick();
      core_arstn = 1'b1;
      tick();
      chk("abort_idle", bus(), RESET_BUS);
      clear_log();
      pulse_start();
      wait_done();
      tick();
      check_run("run2");

      chk("total_cmds",        32'(total_cmds), 32'd13);
      chk("cs_n_with_cke_low", 32'(cs_bad),     32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
